// File: rtl/block_memory_retrieval_if.sv
// Bundle of every signal the retrieval block exchanges with its surroundings:
// the query handshake, the port-A read side of HNM/HCM/HIM, and the hit stream.
// "master" is the retrieval block's view; "slave" is the environment's view.
interface block_memory_retrieval_if #(
   parameter int SSIDBITS         = 10,
   parameter int COLINDEXBITS     = 5,
   parameter int HITINFOBITS      = 8,
   parameter int MAXHITS          = 4,
   parameter int MAXHITNBITS      = 3,
   parameter int ROWINDEXBITS_HIM = 8,
   parameter int NCOLS_HCM        = 16
);
   logic                                storageReady;
   logic                                requestValid;
   logic [SSIDBITS-1:0]                 requestSSID;
   logic                                requestReady;
   logic [SSIDBITS-COLINDEXBITS-1:0]    hnmAddr;
   logic [(2**COLINDEXBITS)-1:0]        hnmData;
   logic [SSIDBITS-1:0]                 hcmAddr;
   logic [NCOLS_HCM-1:0]                hcmData;
   logic [ROWINDEXBITS_HIM-1:0]         himAddr;
   logic [HITINFOBITS*MAXHITS-1:0]      himData;
   logic                                hitValid;
   logic                                hitReady;
   logic [HITINFOBITS-1:0]              hitInfo;
   logic                                hitLast;
   logic                                hitEmpty;
   logic                                hitOverflow;

   modport master (
      input  storageReady, requestValid, requestSSID, hnmData, hcmData, himData, hitReady,
      output requestReady, hnmAddr, hcmAddr, himAddr, hitValid, hitInfo, hitLast,
             hitEmpty, hitOverflow
   );

   modport slave (
      output storageReady, requestValid, requestSSID, hnmData, hcmData, himData, hitReady,
      input  requestReady, hnmAddr, hcmAddr, himAddr, hitValid, hitInfo, hitLast,
             hitEmpty, hitOverflow
   );
endinterface

// File: rtl/block_memory_retrieval.sv
// Read-out stage for the HNM/HCM/HIM block-memory store. One SSID query at a
// time: check the HNM "new hit" bit and the HCM count/address word, then, if
// the SSID was hit, fetch the HIM word and stream its hit-info slots oldest
// first. Only the read port A of each memory is driven; nothing is written.
module block_memory_retrieval #(
   parameter int SSIDBITS         = 10,
   parameter int COLINDEXBITS     = 5,
   parameter int HITINFOBITS      = 8,
   parameter int MAXHITS          = 4,
   parameter int MAXHITNBITS      = 3,
   parameter int ROWINDEXBITS_HIM = 8,
   parameter int NCOLS_HCM        = 16
) (
   input logic                      clock,
   input logic                      resetN,
   block_memory_retrieval_if.master bus
);

   localparam int ROWBITS  = SSIDBITS - COLINDEXBITS;
   localparam int WORDBITS = HITINFOBITS * MAXHITS;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      CHECK,
      HIMADDR,
      HIMDATA,
      EMIT
   } stateT;

   stateT                       state, nextState;
   logic [COLINDEXBITS-1:0]     colReg, nextCol;
   logic [ROWBITS-1:0]          hnmAddrReg, nextHnmAddr;
   logic [SSIDBITS-1:0]         hcmAddrReg, nextHcmAddr;
   logic [ROWINDEXBITS_HIM-1:0] himAddrReg, nextHimAddr;
   logic [MAXHITNBITS-1:0]      remaining, nextRemaining;
   logic [WORDBITS-1:0]         himWord, nextHimWord;
   logic                        hitValidReg, nextHitValid;
   logic [HITINFOBITS-1:0]      hitInfoReg, nextHitInfo;
   logic                        hitLastReg, nextHitLast;
   logic                        hitEmptyReg, nextHitEmpty;
   logic                        hitOverflowReg, nextHitOverflow;

   logic                        requestReadyInt;
   logic                        hnmBit;
   logic [MAXHITNBITS-1:0]      hitCount;
   logic [MAXHITNBITS-1:0]      decremented;
   logic                        countTooBig;
   logic                        unusedHcmBits;

   // Slot 0 holds the newest hit, so beats walk the slot index downwards.
   function automatic logic [HITINFOBITS-1:0] slotOf(input logic [WORDBITS-1:0] word,
                                                     input logic [MAXHITNBITS-1:0] idx);
      logic [HITINFOBITS-1:0] result;
      result = '0;
      for (int s = 0; s < MAXHITS; s++) begin
         if (int'(idx) == s) result = word[s*HITINFOBITS +: HITINFOBITS];
      end
      return result;
   endfunction

   assign requestReadyInt  = (state == IDLE) && bus.storageReady;
   assign hnmBit           = bus.hnmData[colReg];
   assign hitCount         = bus.hcmData[MAXHITNBITS-1:0];
   assign countTooBig      = int'(hitCount) > MAXHITS;
   assign decremented      = remaining - MAXHITNBITS'(1);
   assign unusedHcmBits    = ^bus.hcmData;

   assign bus.requestReady = requestReadyInt;
   assign bus.hnmAddr      = hnmAddrReg;
   assign bus.hcmAddr      = hcmAddrReg;
   assign bus.himAddr      = himAddrReg;
   assign bus.hitValid     = hitValidReg;
   assign bus.hitInfo      = hitInfoReg;
   assign bus.hitLast      = hitLastReg;
   assign bus.hitEmpty     = hitEmptyReg;
   assign bus.hitOverflow  = hitOverflowReg;

   // Registers for the FSM and all datapath state; reset abandons any response.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state          <= IDLE;
         colReg         <= '0;
         hnmAddrReg     <= '0;
         hcmAddrReg     <= '0;
         himAddrReg     <= '0;
         remaining      <= '0;
         himWord        <= '0;
         hitValidReg    <= 1'b0;
         hitInfoReg     <= '0;
         hitLastReg     <= 1'b0;
         hitEmptyReg    <= 1'b0;
         hitOverflowReg <= 1'b0;
      end else begin
         state          <= nextState;
         colReg         <= nextCol;
         hnmAddrReg     <= nextHnmAddr;
         hcmAddrReg     <= nextHcmAddr;
         himAddrReg     <= nextHimAddr;
         remaining      <= nextRemaining;
         himWord        <= nextHimWord;
         hitValidReg    <= nextHitValid;
         hitInfoReg     <= nextHitInfo;
         hitLastReg     <= nextHitLast;
         hitEmptyReg    <= nextHitEmpty;
         hitOverflowReg <= nextHitOverflow;
      end
   end

   // Next-state and next-output logic; everything holds unless a state says otherwise.
   always_comb begin
      nextState       = state;
      nextCol         = colReg;
      nextHnmAddr     = hnmAddrReg;
      nextHcmAddr     = hcmAddrReg;
      nextHimAddr     = himAddrReg;
      nextRemaining   = remaining;
      nextHimWord     = himWord;
      nextHitValid    = hitValidReg;
      nextHitInfo     = hitInfoReg;
      nextHitLast     = hitLastReg;
      nextHitEmpty    = hitEmptyReg;
      nextHitOverflow = hitOverflowReg;

      case (state)
         IDLE: begin
            if (bus.requestValid && requestReadyInt) begin
               nextCol     = bus.requestSSID[COLINDEXBITS-1:0];
               nextHnmAddr = bus.requestSSID[SSIDBITS-1:COLINDEXBITS];
               nextHcmAddr = bus.requestSSID;
               nextState   = ADDR;
            end
         end
         ADDR: begin
            nextState = CHECK;
         end
         CHECK: begin
            if (!hnmBit || (hitCount == '0)) begin
               nextHitValid    = 1'b1;
               nextHitEmpty    = 1'b1;
               nextHitLast     = 1'b1;
               nextHitInfo     = '0;
               nextHitOverflow = 1'b0;
               nextState       = EMIT;
            end else begin
               nextHimAddr     = bus.hcmData[NCOLS_HCM-1 -: ROWINDEXBITS_HIM];
               nextRemaining   = countTooBig ? MAXHITNBITS'(MAXHITS) : hitCount;
               nextHitOverflow = countTooBig;
               nextState       = HIMADDR;
            end
         end
         HIMADDR: begin
            nextState = HIMDATA;
         end
         HIMDATA: begin
            nextHimWord  = bus.himData;
            nextHitValid = 1'b1;
            nextHitEmpty = 1'b0;
            nextHitInfo  = slotOf(bus.himData, decremented);
            nextHitLast  = (remaining == MAXHITNBITS'(1));
            nextState    = EMIT;
         end
         EMIT: begin
            if (hitValidReg && bus.hitReady) begin
               if (hitLastReg) begin
                  nextHitValid    = 1'b0;
                  nextHitLast     = 1'b0;
                  nextHitEmpty    = 1'b0;
                  nextHitOverflow = 1'b0;
                  nextHitInfo     = '0;
                  nextState       = IDLE;
               end else begin
                  nextRemaining = decremented;
                  nextHitInfo   = slotOf(himWord, decremented - MAXHITNBITS'(1));
                  nextHitLast   = (decremented == MAXHITNBITS'(1));
               end
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_block_memory_retrieval.sv
// Self-checking bench for block_memory_retrieval: behavioural 1-cycle-latency
// models of HNM/HCM/HIM, a table of query vectors, and hand-written sequences
// for backpressure, mid-stream reset, acceptance gating and back-to-back queries.
module tb_block_memory_retrieval;

   logic clock = 1'b0;
   logic resetN;

   always #5 clock = ~clock;

   block_memory_retrieval_if bus ();

   block_memory_retrieval dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus)
   );

   logic [31:0] hnmMem [32];
   logic [15:0] hcmMem [1024];
   logic [31:0] himMem [256];

   // Memory port-A models: address sampled on the edge, data valid afterwards.
   always @(posedge clock) begin
      bus.hnmData <= hnmMem[bus.hnmAddr];
      bus.hcmData <= hcmMem[bus.hcmAddr];
      bus.himData <= himMem[bus.himAddr];
   end

   typedef struct {
      logic [9:0]       ssid;
      logic [31:0]      hnmRow;
      logic [15:0]      hcmWord;
      logic [31:0]      himWord;
      int               expBeats;
      logic [0:3][7:0]  expInfo;
      bit               expEmpty;
      bit               expOverflow;
   } vecT;

   vecT vecs [7];

   int errors;
   int checks;

   int        nBeats;
   logic [7:0] gotInfo [8];
   bit        gotLast [8];
   bit        gotEmpty [8];
   bit        gotOver [8];
   int        gotEdge [8];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic loadVector(input vecT v);
      hnmMem[v.ssid[9:5]]      = v.hnmRow;
      hcmMem[v.ssid]           = v.hcmWord;
      himMem[v.hcmWord[15:8]]  = v.himWord;
   endtask

   // Present a query and return just after its accepting edge (E0).
   task automatic applyStimulus(input logic [9:0] ssid, input bit dropValid);
      int guard = 0;
      bus.requestValid = 1'b1;
      bus.requestSSID  = ssid;
      while (!bus.requestReady && guard < 50) begin
         tick();
         guard++;
      end
      checkOutput("acceptReady", 32'(bus.requestReady), 32'd1);
      tick();
      if (dropValid) bus.requestValid = 1'b0;
   endtask

   // Record beats with edge numbers relative to E0, optionally stalling one beat.
   task automatic collectResponse(input int stallBeat, input int stallCycles,
                                  input logic [7:0] stallInfo);
      int edges = 0;
      bit done  = 1'b0;
      nBeats        = 0;
      bus.hitReady  = 1'b1;
      while (!done && edges < 60) begin
         tick();
         edges++;
         if (bus.hitValid) begin
            if (nBeats < 8) begin
               gotInfo[nBeats]  = bus.hitInfo;
               gotLast[nBeats]  = bus.hitLast;
               gotEmpty[nBeats] = bus.hitEmpty;
               gotOver[nBeats]  = bus.hitOverflow;
               gotEdge[nBeats]  = edges;
            end
            if (nBeats == stallBeat) begin
               bus.hitReady = 1'b0;
               for (int c = 0; c < stallCycles; c++) begin
                  tick();
                  edges++;
                  checkOutput("stallValid", 32'(bus.hitValid), 32'd1);
                  checkOutput("stallInfo", 32'(bus.hitInfo), 32'(stallInfo));
               end
               bus.hitReady = 1'b1;
            end
            if (bus.hitLast) done = 1'b1;
            nBeats++;
         end
      end
      checkOutput("responseDone", 32'(done), 32'd1);
   endtask

   task automatic checkResponse(input vecT v, input int stallBeat, input int stallCycles);
      int expEdge;
      checkOutput("beatCount", 32'(nBeats), 32'(v.expBeats));
      for (int i = 0; i < v.expBeats && i < nBeats && i < 8; i++) begin
         expEdge = (v.expEmpty ? 2 : 4) + i + ((stallBeat >= 0 && i > stallBeat) ? stallCycles : 0);
         checkOutput($sformatf("beatInfo[%0d]", i), 32'(gotInfo[i]), 32'(v.expInfo[i]));
         checkOutput($sformatf("beatLast[%0d]", i), 32'(gotLast[i]), 32'(i == v.expBeats - 1));
         checkOutput($sformatf("beatEmpty[%0d]", i), 32'(gotEmpty[i]), 32'(v.expEmpty));
         checkOutput($sformatf("beatOverflow[%0d]", i), 32'(gotOver[i]), 32'(v.expOverflow));
         checkOutput($sformatf("beatEdge[%0d]", i), 32'(gotEdge[i]), 32'(expEdge));
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 32; i++)   hnmMem[i] = '0;
      for (int i = 0; i < 1024; i++) hcmMem[i] = '0;
      for (int i = 0; i < 256; i++)  himMem[i] = '0;

      // ssid, hnmRow, hcmWord, himWord, beats, beat words, empty, overflow
      vecs[0] = '{10'h2A5, 32'h0000_0000, 16'h1703, 32'h0000_0000, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0};
      vecs[1] = '{10'h2A5, 32'h0000_0020, 16'h1703, 32'h55A1_B2C3, 3, {8'hA1, 8'hB2, 8'hC3, 8'h00}, 1'b0, 1'b0};
      vecs[2] = '{10'h2A5, 32'h0000_0020, 16'h1700, 32'h55A1_B2C3, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0};
      vecs[3] = '{10'h2A5, 32'h0000_0020, 16'h4006, 32'h1122_3344, 4, {8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 1'b1};
      vecs[4] = '{10'h05F, 32'h8000_0000, 16'h9901, 32'hDEAD_BEEF, 1, {8'hEF, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0};
      vecs[5] = '{10'h3E0, 32'h0000_0001, 16'h0204, 32'h0102_0304, 4, {8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, 1'b0};
      vecs[6] = '{10'h2A5, 32'hFFFF_FFDF, 16'h1703, 32'h55A1_B2C3, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0};

      resetN           = 1'b0;
      bus.storageReady = 1'b1;
      bus.requestValid = 1'b0;
      bus.requestSSID  = '0;
      bus.hitReady     = 1'b1;
      #3;
      checkOutput("resetHitValid", 32'(bus.hitValid), 32'd0);
      checkOutput("resetHitLast", 32'(bus.hitLast), 32'd0);
      checkOutput("resetHitEmpty", 32'(bus.hitEmpty), 32'd0);
      checkOutput("resetHitOverflow", 32'(bus.hitOverflow), 32'd0);
      checkOutput("resetHitInfo", 32'(bus.hitInfo), 32'd0);
      checkOutput("resetHnmAddr", 32'(bus.hnmAddr), 32'd0);
      checkOutput("resetHcmAddr", 32'(bus.hcmAddr), 32'd0);
      checkOutput("resetHimAddr", 32'(bus.himAddr), 32'd0);
      checkOutput("resetRequestReady", 32'(bus.requestReady), 32'd1);
      #9 resetN = 1'b1;
      tick();

      $display("[TB] table-driven queries");
      for (int v = 0; v < 7; v++) begin
         loadVector(vecs[v]);
         applyStimulus(vecs[v].ssid, 1'b1);
         checkOutput("hnmAddr", 32'(bus.hnmAddr), 32'(vecs[v].ssid[9:5]));
         checkOutput("hcmAddr", 32'(bus.hcmAddr), 32'(vecs[v].ssid));
         collectResponse(-1, 0, 8'h00);
         checkResponse(vecs[v], -1, 0);
         if (!vecs[v].expEmpty)
            checkOutput("himAddr", 32'(bus.himAddr), 32'(vecs[v].hcmWord[15:8]));
      end

      $display("[TB] backpressure on second beat, storageReady dropped mid-query");
      loadVector(vecs[1]);
      applyStimulus(vecs[1].ssid, 1'b1);
      bus.storageReady = 1'b0;
      collectResponse(1, 3, 8'hB2);
      bus.storageReady = 1'b1;
      checkResponse(vecs[1], 1, 3);

      $display("[TB] reset in the middle of a stream");
      loadVector(vecs[3]);
      applyStimulus(vecs[3].ssid, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("preResetValid", 32'(bus.hitValid), 32'd1);
      checkOutput("preResetInfo", 32'(bus.hitInfo), 32'h22);
      checkOutput("preResetOverflow", 32'(bus.hitOverflow), 32'd1);
      resetN = 1'b0;
      #1;
      checkOutput("midResetValid", 32'(bus.hitValid), 32'd0);
      checkOutput("midResetLast", 32'(bus.hitLast), 32'd0);
      checkOutput("midResetEmpty", 32'(bus.hitEmpty), 32'd0);
      checkOutput("midResetOverflow", 32'(bus.hitOverflow), 32'd0);
      checkOutput("midResetHimAddr", 32'(bus.himAddr), 32'd0);
      #2 resetN = 1'b1;
      checkOutput("postResetReady", 32'(bus.requestReady), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("postResetNoBeat", 32'(bus.hitValid), 32'd0);
      end

      $display("[TB] acceptance gated by storageReady");
      bus.storageReady = 1'b0;
      bus.requestValid = 1'b1;
      bus.requestSSID  = 10'h3FF;
      #1;
      checkOutput("gatedReady", 32'(bus.requestReady), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("gatedReadyHeld", 32'(bus.requestReady), 32'd0);
         checkOutput("gatedHnmAddr", 32'(bus.hnmAddr), 32'd0);
         checkOutput("gatedHcmAddr", 32'(bus.hcmAddr), 32'd0);
      end
      bus.requestValid = 1'b0;
      bus.storageReady = 1'b1;
      #1;
      checkOutput("ungatedReady", 32'(bus.requestReady), 32'd1);
      tick();

      $display("[TB] back-to-back queries");
      loadVector(vecs[4]);
      loadVector(vecs[5]);
      applyStimulus(vecs[4].ssid, 1'b0);
      bus.requestSSID = vecs[5].ssid;
      collectResponse(-1, 0, 8'h00);
      checkResponse(vecs[4], -1, 0);
      checkOutput("b2bHcmHeld", 32'(bus.hcmAddr), 32'(vecs[4].ssid));
      checkOutput("b2bReadyBusy", 32'(bus.requestReady), 32'd0);
      tick();
      checkOutput("b2bReadyAfterLast", 32'(bus.requestReady), 32'd1);
      checkOutput("b2bNoBeatGap", 32'(bus.hitValid), 32'd0);
      tick();
      bus.requestValid = 1'b0;
      checkOutput("b2bHnmAddr", 32'(bus.hnmAddr), 32'(vecs[5].ssid[9:5]));
      checkOutput("b2bHcmAddr", 32'(bus.hcmAddr), 32'(vecs[5].ssid));
      collectResponse(-1, 0, 8'h00);
      checkResponse(vecs[5], -1, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/block_memory_retrieval.md
Name: block_memory_retrieval

Overview:
Downstream read-out stage for the HNM/HCM/HIM block-memory store. It accepts one SSID query at a time and reads the HNM "new hit" bit and the HCM count/address word. If the SSID was hit, it reads the HIM word and streams the stored hit-info words out one per beat, oldest first. It drives the otherwise unused read port A of each of the three memories and never writes them.

Parameters:
SSIDBITS, 10, SSID width
COLINDEXBITS, 5, HNM column bits; HNM row = SSID[SSIDBITS-1:COLINDEXBITS], column = SSID[COLINDEXBITS-1:0]
HITINFOBITS, 8, width of one hit-info word
MAXHITS, 4, hit slots per HIM word
MAXHITNBITS, 3, width of the HCM hit-count field
ROWINDEXBITS_HIM, 8, HIM address width
NCOLS_HCM, 16, HCM word width; count in [MAXHITNBITS-1:0], HIM address in [NCOLS_HCM-1:NCOLS_HCM-ROWINDEXBITS_HIM]

Ports:
clock  in  1  single clock; all state on posedge
resetN  in  1  asynchronous active-low reset
storageReady  in  1  writer idle; queries are accepted only while high
requestValid  in  1  query present
requestSSID  in  SSIDBITS  SSID to look up
requestReady  out  1  = (state==IDLE) && storageReady, combinational
hnmAddr  out  SSIDBITS-COLINDEXBITS  HNM port-A address, registered
hnmData  in  2**COLINDEXBITS  HNM port-A read data, 1-cycle latency
hcmAddr  out  SSIDBITS  HCM port-A address, registered
hcmData  in  NCOLS_HCM  HCM port-A read data
himAddr  out  ROWINDEXBITS_HIM  HIM port-A address, registered
himData  in  HITINFOBITS*MAXHITS  HIM port-A read data
hitValid  out  1  output beat valid
hitReady  in  1  consumer accepts beat
hitInfo  out  HITINFOBITS  hit-info word; 0 on empty beat
hitLast  out  1  last beat of this response
hitEmpty  out  1  SSID has no hits; single beat
hitOverflow  out  1  stored count exceeded MAXHITS; held high on every beat of the response

Behaviour:
- Reset (resetN low, asynchronous): state=IDLE; hitValid, hitLast, hitEmpty, hitOverflow=0; hitInfo=0; all three addresses=0; internal count and word registers=0. Reset in any state, including mid-stream, abandons the response with no further beats.
- States: IDLE, ADDR, CHECK, HIMADDR, HIMDATA, EMIT.
- Edge E0 is the edge at which requestValid && requestReady is sampled high.
  - IDLE -> ADDR at E0: latch SSID; hnmAddr <= SSID row; hcmAddr <= SSID.
- ADDR -> CHECK unconditionally. The memories capture the addresses on this edge.
- CHECK, where hnmData and hcmData are valid:
  - bit = hnmData[column]; n = hcmData[MAXHITNBITS-1:0].
  - If bit==0 or n==0: at E2 assert hitValid, hitEmpty=1, hitLast=1, hitInfo=0; go to EMIT.
  - Otherwise: himAddr <= HCM address field; remaining <= min(n, MAXHITS); hitOverflow <= (n > MAXHITS); go to HIMADDR.
- HIMADDR -> HIMDATA unconditionally.
- HIMDATA: latch himData; assert hitValid with the first beat at E4; go to EMIT.
- Slot order: slot 0 (bits [HITINFOBITS-1:0]) is the newest hit; slot n-1 is the oldest.
  - Beats present slot remaining-1 down to slot 0, so the oldest hit comes first.
  - With overflow clamped to MAXHITS, the first beat is slot MAXHITS-1.
- EMIT: outputs hold steady while hitValid && !hitReady.
  - On hitValid && hitReady with hitLast: hitValid and flags <= 0; go to IDLE.
  - Otherwise: remaining-1, next slot presented, hitLast = (remaining==1 after the decrement).
- Latency: empty response 2 edges after E0; first hit beat 4 edges after E0; one beat per cycle with hitReady held high.
- No new query is accepted until the last beat of the current response is taken. requestReady first rises again in the cycle after the final handshake.
- storageReady is only sampled for acceptance. A drop mid-query does not abort the query; the writer guarantees it does not start writing in that window.

Test Plan:
- Reset: assert resetN=0 mid-stream with hitValid=1 -> hitValid, hitLast, hitEmpty and hitOverflow are 0 immediately; after release requestReady=1 with storageReady=1.
- Empty SSID: query 0x2A5 with HNM row 0x15 = 0 -> hnmAddr=0x15, hcmAddr=0x2A5; 2 edges after E0 one beat appears with hitEmpty=1, hitLast=1, hitInfo=0.
- Hit: HNM row 0x15 bit 5 = 1; HCM = count 3, addr 0x17; HIM[0x17] slots 2,1,0 = 0xA1,0xB2,0xC3 -> himAddr=0x17; beats 0xA1, 0xB2, 0xC3 on consecutive cycles from E0+4; hitLast only on 0xC3.
- Backpressure: same as the Hit scenario with hitReady low for 3 cycles on beat 2 -> 0xB2 held stable; total 3 beats, no loss or duplication.
- Overflow and gating: HCM count 6 with MAXHITS=4 -> 4 beats (slots 3..0), hitOverflow=1 on all of them. Separately, storageReady=0 with requestValid=1 -> requestReady=0 and no addresses change.
- Back-to-back: two queries presented continuously -> the second is accepted the cycle after the first response's last handshake; responses do not interleave.
